// File: rtl/alu_interface.sv
// UART-to-ALU frame sequencer: collects operand A, operand B and opcode bytes,
// drives the ALU, then hands the result byte to the UART transmitter.
module alu_interface #(
    parameter int unsigned NB_DATA     = 8,
    parameter int unsigned NB_OPERADOR = 6,
    parameter int unsigned N_TIMEOUT   = 50000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NB_DATA-1:0]     i_rx_data,
    input  logic                   i_rx_done,
    input  logic [NB_DATA-1:0]     i_alu_result,
    input  logic                   i_alu_done,
    input  logic                   i_tx_done,
    output logic [NB_DATA-1:0]     o_dato_a,
    output logic [NB_DATA-1:0]     o_dato_b,
    output logic [NB_OPERADOR-1:0] o_operador,
    output logic                   o_alu_valid,
    output logic [NB_DATA-1:0]     o_tx_data,
    output logic                   o_tx_start,
    output logic                   o_error
);

    localparam int unsigned NB_CNT = (N_TIMEOUT > 2) ? $clog2(N_TIMEOUT) : 1;
    localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(N_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StWaitA,
        StWaitB,
        StWaitOp,
        StExec,
        StSend,
        StWaitTx
    } state_t;

    state_t                 state_q, state_d;
    logic [NB_CNT-1:0]      cnt_q, cnt_d;
    logic [NB_DATA-1:0]     dato_a_q, dato_a_d;
    logic [NB_DATA-1:0]     dato_b_q, dato_b_d;
    logic [NB_OPERADOR-1:0] operador_q, operador_d;
    logic                   alu_valid_q, alu_valid_d;
    logic [NB_DATA-1:0]     tx_data_q, tx_data_d;
    logic                   tx_start_q, tx_start_d;
    logic                   error_q, error_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StWaitA;
            cnt_q       <= '0;
            dato_a_q    <= '0;
            dato_b_q    <= '0;
            operador_q  <= '0;
            alu_valid_q <= 1'b0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dato_a_q    <= dato_a_d;
            dato_b_q    <= dato_b_d;
            operador_q  <= operador_d;
            alu_valid_q <= alu_valid_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dato_a_d    = dato_a_q;
        dato_b_d    = dato_b_q;
        operador_d  = operador_q;
        alu_valid_d = alu_valid_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        error_d     = 1'b0;

        case (state_q)
            StWaitA: begin
                if (i_rx_done) begin
                    dato_a_d = i_rx_data;
                    cnt_d    = '0;
                    state_d  = StWaitB;
                end
            end
            StWaitB: begin
                // A byte landing on the timeout cycle wins over the timeout.
                if (i_rx_done) begin
                    dato_b_d = i_rx_data;
                    cnt_d    = '0;
                    state_d  = StWaitOp;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    error_d = 1'b1;
                    state_d = StWaitA;
                end else begin
                    cnt_d = cnt_q + NB_CNT'(1);
                end
            end
            StWaitOp: begin
                if (i_rx_done) begin
                    operador_d  = i_rx_data[NB_OPERADOR-1:0];
                    alu_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = StExec;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    error_d = 1'b1;
                    state_d = StWaitA;
                end else begin
                    cnt_d = cnt_q + NB_CNT'(1);
                end
            end
            StExec: begin
                alu_valid_d = 1'b1;
                if (i_alu_done) begin
                    tx_data_d   = i_alu_result;
                    alu_valid_d = 1'b0;
                    tx_start_d  = 1'b1;
                    state_d     = StSend;
                end
            end
            StSend: begin
                state_d = StWaitTx;
            end
            StWaitTx: begin
                if (i_tx_done) begin
                    state_d = StWaitA;
                end
            end
            default: begin
                state_d = StWaitA;
            end
        endcase
    end

    assign o_dato_a    = dato_a_q;
    assign o_dato_b    = dato_b_q;
    assign o_operador  = operador_q;
    assign o_alu_valid = alu_valid_q;
    assign o_tx_data   = tx_data_q;
    assign o_tx_start  = tx_start_q;
    assign o_error     = error_q;

endmodule

// File: tb/tb_alu_interface.sv
// Directed bench for alu_interface with a small reference ALU closing the loop
// between the operand/opcode outputs and the result input.
module tb_alu_interface;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] alu_result;
    logic       alu_done;
    logic       tx_done;
    logic [7:0] dato_a;
    logic [7:0] dato_b;
    logic [5:0] operador;
    logic       alu_valid;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       error;
    logic       alu_hold;

    int vec_cnt  = 0;
    int mis_cnt  = 0;
    int err_seen = 0;

    alu_interface #(
        .NB_DATA    (8),
        .NB_OPERADOR(6),
        .N_TIMEOUT  (20)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx_data   (rx_data),
        .i_rx_done   (rx_done),
        .i_alu_result(alu_result),
        .i_alu_done  (alu_done),
        .i_tx_done   (tx_done),
        .o_dato_a    (dato_a),
        .o_dato_b    (dato_b),
        .o_operador  (operador),
        .o_alu_valid (alu_valid),
        .o_tx_data   (tx_data),
        .o_tx_start  (tx_start),
        .o_error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: MIPS-style function codes.
    always_comb begin
        logic signed [7:0] sa;
        sa = dato_a;
        case (operador)
            6'h20:   alu_result = dato_a + dato_b;
            6'h22:   alu_result = dato_a - dato_b;
            6'h24:   alu_result = dato_a & dato_b;
            6'h25:   alu_result = dato_a | dato_b;
            6'h26:   alu_result = dato_a ^ dato_b;
            6'h27:   alu_result = ~(dato_a | dato_b);
            6'h03:   alu_result = sa >>> dato_b;
            6'h02:   alu_result = dato_a >> dato_b;
            default: alu_result = 8'h00;
        endcase
    end
    assign alu_done = alu_valid & ~alu_hold;

    always @(negedge clk) if (error === 1'b1) err_seen++;

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1 rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1 rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
    endtask

    task automatic wait_tx(output logic [7:0] d, output logic ok);
        ok = 1'b0;
        d  = 8'h00;
        for (int i = 0; i < 10; i++) begin
            if (!ok) begin
                @(negedge clk);
                if (tx_start === 1'b1) begin
                    ok = 1'b1;
                    d  = tx_data;
                end
            end
        end
        pulse_tx_done();
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             output logic [7:0] d, output logic ok);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        wait_tx(d, ok);
    endtask

    task automatic test_reset();
        @(negedge clk);
        vec_cnt++;
        if ({dato_a, dato_b, operador, alu_valid, tx_data, tx_start, error} !== 38'h0) begin
            mis_cnt++;
            $display("FAIL reset_outputs: got %h want 0",
                     {dato_a, dato_b, operador, alu_valid, tx_data, tx_start, error});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        @(negedge clk);
        vec_cnt++;
        if ({dato_a, dato_b, operador} !== {8'h05, 8'h03, 6'b100000}) begin
            mis_cnt++;
            $display("FAIL basic_regs: got %h/%h/%b want 05/03/100000", dato_a, dato_b, operador);
        end
        vec_cnt++;
        if ({alu_valid, tx_start} !== 2'b10) begin
            mis_cnt++;
            $display("FAIL basic_exec: got valid=%b start=%b want 1/0", alu_valid, tx_start);
        end
        @(negedge clk);
        vec_cnt++;
        if ({alu_valid, tx_start, tx_data} !== {2'b01, 8'h08}) begin
            mis_cnt++;
            $display("FAIL basic_send: got valid=%b start=%b data=%h want 0/1/08",
                     alu_valid, tx_start, tx_data);
        end
        @(negedge clk);
        vec_cnt++;
        if (tx_start !== 1'b0) begin
            mis_cnt++;
            $display("FAIL basic_start_width: got start=%b want 0", tx_start);
        end
        pulse_tx_done();
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic       ok;
        run_frame(8'h02, 8'h07, 8'hE2, d, ok);
        vec_cnt++;
        if ({ok, d} !== {1'b1, 8'hFB}) begin
            mis_cnt++;
            $display("FAIL b2b_result: got ok=%b data=%h want 1/fb", ok, d);
        end
        vec_cnt++;
        if (operador !== 6'b100010) begin
            mis_cnt++;
            $display("FAIL b2b_opcode: got %b want 100010", operador);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] d;
        logic       ok;
        int         err0;
        int         got_at;
        err0   = err_seen;
        got_at = -1;
        send_byte(8'h11);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (error === 1'b1 && got_at < 0) got_at = i;
        end
        vec_cnt++;
        if (got_at != 20) begin
            mis_cnt++;
            $display("FAIL timeout_cycle: got %0d want 20", got_at);
        end
        vec_cnt++;
        if (err_seen - err0 != 1) begin
            mis_cnt++;
            $display("FAIL timeout_pulses: got %0d want 1", err_seen - err0);
        end
        vec_cnt++;
        if (dato_a !== 8'h11) begin
            mis_cnt++;
            $display("FAIL timeout_retain: got %h want 11", dato_a);
        end
        run_frame(8'h01, 8'h01, 8'h24, d, ok);
        vec_cnt++;
        if ({ok, d, dato_a} !== {1'b1, 8'h01, 8'h01}) begin
            mis_cnt++;
            $display("FAIL timeout_recover: got ok=%b data=%h a=%h want 1/01/01", ok, d, dato_a);
        end
    endtask

    task automatic test_timeout_edge();
        logic [7:0] d;
        logic       ok;
        int         err0;
        err0 = err_seen;
        send_byte(8'h10);
        repeat (19) @(posedge clk);
        #1 rx_data = 8'h33;
        rx_done = 1'b1;
        @(posedge clk);
        #1 rx_done = 1'b0;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if (dato_b !== 8'h33) begin
            mis_cnt++;
            $display("FAIL edge_capture: got %h want 33", dato_b);
        end
        vec_cnt++;
        if (err_seen != err0) begin
            mis_cnt++;
            $display("FAIL edge_no_error: got %0d pulses want 0", err_seen - err0);
        end
        send_byte(8'h20);
        wait_tx(d, ok);
        vec_cnt++;
        if ({ok, d} !== {1'b1, 8'h43}) begin
            mis_cnt++;
            $display("FAIL edge_result: got ok=%b data=%h want 1/43", ok, d);
        end
    endtask

    task automatic test_ignore();
        logic [7:0] d;
        logic       ok;
        alu_hold = 1'b1;
        send_byte(8'h07);
        send_byte(8'h02);
        send_byte(8'h20);
        rx_data = 8'hAA;
        rx_done = 1'b1;
        @(posedge clk);
        #1 rx_done = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({alu_valid, tx_start} !== 2'b10) begin
            mis_cnt++;
            $display("FAIL exec_hold: got valid=%b start=%b want 1/0", alu_valid, tx_start);
        end
        vec_cnt++;
        if ({dato_a, dato_b, operador} !== {8'h07, 8'h02, 6'h20}) begin
            mis_cnt++;
            $display("FAIL exec_ignore: got %h/%h/%h want 07/02/20", dato_a, dato_b, operador);
        end
        alu_hold = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({tx_start, tx_data} !== {1'b1, 8'h09}) begin
            mis_cnt++;
            $display("FAIL exec_release: got start=%b data=%h want 1/09", tx_start, tx_data);
        end
        @(posedge clk);
        #1 rx_data = 8'hAA;
        rx_done = 1'b1;
        @(posedge clk);
        #1 rx_done = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({dato_a, alu_valid, tx_start} !== {8'h07, 2'b00}) begin
            mis_cnt++;
            $display("FAIL waittx_ignore: got a=%h valid=%b start=%b want 07/0/0",
                     dato_a, alu_valid, tx_start);
        end
        pulse_tx_done();
        run_frame(8'h04, 8'h01, 8'h03, d, ok);
        vec_cnt++;
        if ({ok, d, dato_a} !== {1'b1, 8'h02, 8'h04}) begin
            mis_cnt++;
            $display("FAIL sra_frame: got ok=%b data=%h a=%h want 1/02/04", ok, d, dato_a);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic       ok;
        send_byte(8'h0A);
        send_byte(8'h0B);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({dato_a, dato_b, operador, alu_valid, tx_data, tx_start, error} !== 38'h0) begin
            mis_cnt++;
            $display("FAIL async_reset: got %h want 0",
                     {dato_a, dato_b, operador, alu_valid, tx_data, tx_start, error});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_frame(8'h09, 8'h06, 8'h22, d, ok);
        vec_cnt++;
        if ({ok, d} !== {1'b1, 8'h03}) begin
            mis_cnt++;
            $display("FAIL reset_recover: got ok=%b data=%h want 1/03", ok, d);
        end
        vec_cnt++;
        if ({dato_a, dato_b, operador} !== {8'h09, 8'h06, 6'h22}) begin
            mis_cnt++;
            $display("FAIL reset_operands: got %h/%h/%h want 09/06/22", dato_a, dato_b, operador);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_done  = 1'b0;
        tx_done  = 1'b0;
        alu_hold = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout();
        test_timeout_edge();
        test_ignore();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
